alarm_ctrl: RTL and testbench



---
 rtl/alarm_pkg.sv | 34 +++
 rtl/alarm_time_set.sv | 39 +++
 rtl/alarm_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam int unsigned MIN_TENS_MAX = 5;
    localparam int unsigned HOUR_MAX     = 23;
    localparam int unsigned MIN_MAX      = MIN_TENS_MAX * 10 + 9;

    typedef struct packed {
        logic [3:0] hour_tens;
        logic [3:0] hour_ones;
        logic [3:0] min_tens;
        logic [3:0] min_ones;
    } bcd_time_t;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input int unsigned max);
        int unsigned val;
        val = 32'(v[7:4]) * 10 + 32'(v[3:0]);
        if (val >= max) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/alarm_time_set.sv
// BCD alarm hour/minute registers; increments are accepted only in set mode.
module alarm_time_set
    import alarm_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_mode,
    input  logic      inc_hour,
    input  logic      inc_min,
    output bcd_time_t alarm_time
);

    bcd_time_t time_q, time_d;

    // Apply minute and hour increments independently; minutes never carry.
    always_comb begin
        time_d = time_q;
        if (set_mode) begin
            if (inc_min) begin
                {time_d.min_tens, time_d.min_ones} = bcd2_inc({time_q.min_tens, time_q.min_ones}, MIN_MAX);
            end
            if (inc_hour) begin
                {time_d.hour_tens, time_d.hour_ones} = bcd2_inc({time_q.hour_tens, time_q.hour_ones}, HOUR_MAX);
            end
        end
    end

    // Alarm time register.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    assign alarm_time = time_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: ring/snooze/stop FSM, ring and snooze timers, buzzer tone.
// Optional macro ALARM_SNOOZE_LIMIT_EN caps the number of snoozes per alarm at MAX_SNOOZE.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned BUZZ_DIV     = 1000
`ifdef ALARM_SNOOZE_LIMIT_EN
    ,
    parameter int unsigned MAX_SNOOZE   = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_HZ,
    input  logic [3:0] hour_ten,
    input  logic [3:0] hour_one,
    input  logic [3:0] minute_ten,
    input  logic [3:0] minute_one,
    input  logic [3:0] second_ten,
    input  logic [3:0] second_one,
    input  logic       alarm_en,
    input  logic       set_mode,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       snooze,
    input  logic       stop,
    output logic [3:0] alarm_hour_tens,
    output logic [3:0] alarm_hour_ones,
    output logic [3:0] alarm_minute_tens,
    output logic [3:0] alarm_minute_ones,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    localparam int unsigned RING_W   = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
    localparam int unsigned SNZ_LOAD = SNOOZE_MIN * 60;
    localparam int unsigned SNZ_W    = $clog2(SNZ_LOAD + 1);
    localparam int unsigned DIV_W    = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

    bcd_time_t          alarm_time;
    state_t             state_q, state_d;
    logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]   snz_cnt_q, snz_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               ringing_q, ringing_d;
    logic               snoozing_q, snoozing_d;
    logic               buzzer_q, buzzer_d;
    logic               match_c;
    logic               snooze_ok_c;

    alarm_time_set u_time_set (
        .clk        (clk),
        .rst        (rst),
        .set_mode   (set_mode),
        .inc_hour   (inc_hour),
        .inc_min    (inc_min),
        .alarm_time (alarm_time)
    );

    assign match_c = (alarm_time.hour_tens == hour_ten) && (alarm_time.hour_ones == hour_one)
                  && (alarm_time.min_tens == minute_ten) && (alarm_time.min_ones == minute_one)
                  && (second_ten == 4'd0) && (second_one == 4'd0)
                  && one_HZ && alarm_en && !set_mode;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int unsigned NUM_W = $clog2(MAX_SNOOZE + 1);
    logic [NUM_W-1:0] snz_num_q, snz_num_d;
    logic             snz_clr_c;

    assign snooze_ok_c = (snz_num_q != NUM_W'(MAX_SNOOZE));

    // Count accepted snoozes; a RINGING->IDLE exit not caused by stop/disable/set is the timeout.
    always_comb begin
        snz_clr_c = !alarm_en || stop || ((state_q == RINGING) && (state_d == IDLE) && !set_mode);
        snz_num_d = snz_num_q;
        if (snz_clr_c) begin
            snz_num_d = '0;
        end else if ((state_q == RINGING) && (state_d == SNOOZE)) begin
            snz_num_d = snz_num_q + NUM_W'(1);
        end
    end

    // Snooze count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            snz_num_q <= '0;
        end else begin
            snz_num_q <= snz_num_d;
        end
    end
`else
    assign snooze_ok_c = 1'b1;
`endif

    // Next-state and timer logic; disable or edit mode overrides everything.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        if (!alarm_en || set_mode) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match_c) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_d    = IDLE;
                        ring_cnt_d = '0;
                    end else if (snooze && snooze_ok_c) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = SNZ_W'(SNZ_LOAD);
                    end else if (one_HZ) begin
                        if (ring_cnt_q == RING_W'(RING_SECONDS - 1)) begin
                            state_d    = IDLE;
                            ring_cnt_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RING_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_d   = IDLE;
                        snz_cnt_d = '0;
                    end else if (one_HZ) begin
                        snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                        if (snz_cnt_q == SNZ_W'(1)) begin
                            state_d    = RINGING;
                            ring_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Registered state decodes and buzzer divider; divider idles at zero outside RINGING.
    always_comb begin
        ringing_d  = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
        div_d      = '0;
        buzzer_d   = 1'b0;
        if ((state_d == RINGING) && (state_q == RINGING)) begin
            if (div_q == DIV_W'(BUZZ_DIV - 1)) begin
                div_d    = '0;
                buzzer_d = ~buzzer_q;
            end else begin
                div_d    = div_q + DIV_W'(1);
                buzzer_d = buzzer_q;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            div_q      <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            div_q      <= div_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign alarm_hour_tens   = alarm_time.hour_tens;
    assign alarm_hour_ones   = alarm_time.hour_ones;
    assign alarm_minute_tens = alarm_time.min_tens;
    assign alarm_minute_ones = alarm_time.min_ones;
    assign ringing           = ringing_q;
    assign snoozing          = snoozing_q;
    assign buzzer            = buzzer_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (short ring, 1-minute snooze, fast buzzer).
module tb_alarm_ctrl;

    localparam int unsigned RS = 5;
    localparam int unsigned SM = 1;
    localparam int unsigned BD = 4;

    logic       clk = 1'b0;
    logic       rst, one_hz;
    logic [3:0] ht, ho, mt, mo, st, so;
    logic       alarm_en, set_mode, inc_hour, inc_min, snooze, stop;
    logic [3:0] aht, aho, amt, amo;
    logic       ringing, snoozing, buzzer;
    logic [15:0] al;
    int         n_cmp = 0;
    int         n_fail = 0;

    assign al = {aht, aho, amt, amo};

    always #5 clk = ~clk;

    alarm_ctrl #(.RING_SECONDS(RS), .SNOOZE_MIN(SM), .BUZZ_DIV(BD)) dut (
        .clk(clk), .rst(rst), .one_HZ(one_hz),
        .hour_ten(ht), .hour_one(ho), .minute_ten(mt), .minute_one(mo),
        .second_ten(st), .second_one(so),
        .alarm_en(alarm_en), .set_mode(set_mode), .inc_hour(inc_hour), .inc_min(inc_min),
        .snooze(snooze), .stop(stop),
        .alarm_hour_tens(aht), .alarm_hour_ones(aho),
        .alarm_minute_tens(amt), .alarm_minute_ones(amo),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hz(input int n);
        for (int i = 0; i < n; i++) begin
            one_hz = 1'b1; tick(); one_hz = 1'b0;
        end
    endtask

    task automatic set_now(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        {ht, ho} = hh; {mt, mo} = mm; {st, so} = ss;
    endtask

    task automatic press_hour(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hour = 1'b1; tick(); inc_hour = 1'b0;
        end
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min = 1'b1; tick(); inc_min = 1'b0;
        end
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1; tick(); snooze = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    // Match at 07:30:00 and move the clock past the matching second.
    task automatic start_ring();
        set_now(8'h07, 8'h30, 8'h00);
        hz(1);
        set_now(8'h07, 8'h30, 8'h01);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_cmp++; if (al !== 16'h0000) begin n_fail++; $display("FAIL reset_alarm: got %h want 0000", al); end
        n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL reset_ringing: got %b want 0", ringing); end
        n_cmp++; if (snoozing !== 1'b0) begin n_fail++; $display("FAIL reset_snoozing: got %b want 0", snoozing); end
        n_cmp++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    endtask

    task automatic test_set();
        set_mode = 1'b1;
        press_hour(7); press_min(30);
        n_cmp++; if (al !== 16'h0730) begin n_fail++; $display("FAIL set_0730: got %h want 0730", al); end
        press_min(30);
        n_cmp++; if (al !== 16'h0700) begin n_fail++; $display("FAIL min_wrap: got %h want 0700", al); end
        inc_hour = 1'b1; inc_min = 1'b1; tick(); inc_hour = 1'b0; inc_min = 1'b0;
        n_cmp++; if (al !== 16'h0801) begin n_fail++; $display("FAIL both_inc: got %h want 0801", al); end
        press_hour(15);
        n_cmp++; if (al !== 16'h2301) begin n_fail++; $display("FAIL hour_23: got %h want 2301", al); end
        press_hour(1);
        n_cmp++; if (al !== 16'h0001) begin n_fail++; $display("FAIL hour_wrap: got %h want 0001", al); end
        press_hour(7); press_min(29);
        n_cmp++; if (al !== 16'h0730) begin n_fail++; $display("FAIL reprogram: got %h want 0730", al); end
        set_mode = 1'b0;
        press_min(1);
        n_cmp++; if (al !== 16'h0730) begin n_fail++; $display("FAIL inc_locked: got %h want 0730", al); end
    endtask

    task automatic test_ring();
        alarm_en = 1'b1;
        set_now(8'h07, 8'h29, 8'h59); hz(1);
        n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL early_ring: got %b want 0", ringing); end
        set_now(8'h07, 8'h30, 8'h00); tick();
        n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL ring_no_tick: got %b want 0", ringing); end
        hz(1); set_now(8'h07, 8'h30, 8'h01);
        n_cmp++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_latency: got %b want 1", ringing); end
        n_cmp++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL buzz_start: got %b want 0", buzzer); end
        tick(); tick(); tick();
        n_cmp++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL buzz_pre_toggle: got %b want 0", buzzer); end
        tick();
        n_cmp++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL buzz_rise: got %b want 1", buzzer); end
        tick(); tick(); tick(); tick();
        n_cmp++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL buzz_fall: got %b want 0", buzzer); end
        hz(RS - 1);
        n_cmp++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_before_timeout: got %b want 1", ringing); end
        n_cmp++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL buzz_before_timeout: got %b want 1", buzzer); end
        hz(1);
        n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL ring_timeout: got %b want 0", ringing); end
        n_cmp++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL buzz_timeout: got %b want 0", buzzer); end
    endtask

    task automatic test_snooze();
        start_ring();
        tick(); tick(); tick(); tick();
        n_cmp++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL buzz_before_snooze: got %b want 1", buzzer); end
        pulse_snooze();
        n_cmp++; if ({ringing, snoozing, buzzer} !== 3'b010) begin n_fail++; $display("FAIL snooze_enter: got r/s/b=%b want 010", {ringing, snoozing, buzzer}); end
        hz(9);
        pulse_snooze();
        n_cmp++; if (snoozing !== 1'b1) begin n_fail++; $display("FAIL snooze_repress: got %b want 1", snoozing); end
        set_now(8'h07, 8'h30, 8'h00); hz(1); set_now(8'h07, 8'h30, 8'h01);
        n_cmp++; if ({ringing, snoozing} !== 2'b01) begin n_fail++; $display("FAIL match_in_snooze: got r/s=%b want 01", {ringing, snoozing}); end
        hz(SM * 60 - 11);
        n_cmp++; if ({ringing, snoozing} !== 2'b01) begin n_fail++; $display("FAIL snooze_tick59: got r/s=%b want 01", {ringing, snoozing}); end
        hz(1);
        n_cmp++; if ({ringing, snoozing} !== 2'b10) begin n_fail++; $display("FAIL snooze_rering: got r/s=%b want 10", {ringing, snoozing}); end
        pulse_stop();
        n_cmp++; if ({ringing, snoozing} !== 2'b00) begin n_fail++; $display("FAIL stop_ring: got r/s=%b want 00", {ringing, snoozing}); end
    endtask

    task automatic test_back_to_back();
        start_ring();
        snooze = 1'b1; stop = 1'b1; tick(); snooze = 1'b0; stop = 1'b0;
        n_cmp++; if ({ringing, snoozing} !== 2'b00) begin n_fail++; $display("FAIL stop_wins: got r/s=%b want 00", {ringing, snoozing}); end
        start_ring();
        pulse_snooze();
        n_cmp++; if (snoozing !== 1'b1) begin n_fail++; $display("FAIL snooze_again: got %b want 1", snoozing); end
        alarm_en = 1'b0; tick();
        n_cmp++; if (snoozing !== 1'b0) begin n_fail++; $display("FAIL disable_snooze: got %b want 0", snoozing); end
        alarm_en = 1'b1;
        hz(SM * 60 + 10);
        n_cmp++; if ({ringing, snoozing} !== 2'b00) begin n_fail++; $display("FAIL no_rering: got r/s=%b want 00", {ringing, snoozing}); end
    endtask

    task automatic test_set_mode_and_rst();
        set_mode = 1'b1;
        set_now(8'h07, 8'h30, 8'h00); hz(1); set_now(8'h07, 8'h30, 8'h01);
        n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL set_mode_block: got %b want 0", ringing); end
        set_mode = 1'b0;
        start_ring();
        set_mode = 1'b1; tick(); set_mode = 1'b0;
        n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL set_mode_abort: got %b want 0", ringing); end
        start_ring();
        tick(); tick(); tick(); tick();
        n_cmp++; if ({ringing, buzzer} !== 2'b11) begin n_fail++; $display("FAIL pre_rst_ring: got r/b=%b want 11", {ringing, buzzer}); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if ({ringing, snoozing, buzzer} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_ring: got r/s/b=%b want 000", {ringing, snoozing, buzzer}); end
        n_cmp++; if (al !== 16'h0000) begin n_fail++; $display("FAIL rst_alarm: got %h want 0000", al); end
    endtask

`ifdef ALARM_SNOOZE_LIMIT_EN
    task automatic test_snooze_limit();
        set_mode = 1'b1; press_hour(7); press_min(30); set_mode = 1'b0;
        start_ring();
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            hz(SM * 60);
            n_cmp++; if (ringing !== 1'b1) begin n_fail++; $display("FAIL limit_rering%0d: got %b want 1", k, ringing); end
        end
        pulse_snooze();
        n_cmp++; if ({ringing, snoozing} !== 2'b10) begin n_fail++; $display("FAIL limit_4th: got r/s=%b want 10", {ringing, snoozing}); end
        pulse_stop();
        n_cmp++; if (ringing !== 1'b0) begin n_fail++; $display("FAIL limit_stop: got %b want 0", ringing); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; one_hz = 1'b0; alarm_en = 1'b0; set_mode = 1'b0;
        inc_hour = 1'b0; inc_min = 1'b0; snooze = 1'b0; stop = 1'b0;
        set_now(8'h00, 8'h00, 8'h01);
        test_reset();
        test_set();
        test_ring();
        test_snooze();
        test_back_to_back();
        test_set_mode_and_rst();
`ifdef ALARM_SNOOZE_LIMIT_EN
        test_snooze_limit();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
